dmem_responder: RTL and testbench

- Data-memory responder: the memory-side end of the CPU load/store request/response interface.
- Accepts one word-wide request at a time from the datapath initiator.
- Commits writes with byte enables; returns read data after a programmable number of wait states.
- Sits beside the instruction memory. Gives the datapath a realistic, multi-cycle data port to stall against.

---
 rtl/dmem_responder_if.sv | 25 ++
 rtl/dmem_responder.sv | 108 ++++++++++
 tb/tb_dmem_responder.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Load/store request/response bus between the datapath initiator and the
// data-memory responder. The master modport is the initiator side and the
// slave modport is the memory side.
interface dmem_responder_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic [3:0]  req_be_i;
    logic        resp_valid_o;
    logic        resp_ready_i;
    logic [31:0] resp_rdata_o;
    logic        resp_err_o;

    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i, resp_ready_i,
        input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
    );

    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i, resp_ready_i,
        output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, commits stores with
// byte enables and answers after LATENCY wait states. Holds the response under
// backpressure until the initiator takes it.
// Optional feature macro: DMEM_MISALIGN_ERR_EN -- when defined, requests with
// addr[1:0] != 0 leave the array untouched and return an error response.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    dmem_responder_if.slave  bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    // Wait-state counter reload; LATENCY = 0 skips WAIT entirely, so the value is unused then.
    localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q;
    logic [31:0]   rdata_q;
    logic          err_q;
    logic [31:0]   mem [DEPTH_WORDS];

    logic [AW-1:0] idx;
    logic          accept;
    logic          misaligned;
    logic          unused_addr;

    // Upper address bits wrap away; the low two only matter for error detection.
    assign idx         = bus.req_addr_i[AW+1:2];
    assign unused_addr = ^{bus.req_addr_i[31:AW+2], bus.req_addr_i[1:0]};

`ifdef DMEM_MISALIGN_ERR_EN
    assign misaligned = |bus.req_addr_i[1:0];
`else
    assign misaligned = 1'b0;
`endif

    assign bus.resp_rdata_o = rdata_q;
    assign bus.resp_err_o   = err_q;

    // Next-state logic and handshake outputs; ready only in IDLE so a new request
    // can never overlap a response handshake.
    always_comb begin
        state_d          = state_q;
        bus.req_ready_o  = 1'b0;
        bus.resp_valid_o = 1'b0;
        accept           = 1'b0;
        case (state_q)
            IDLE: begin
                bus.req_ready_o = 1'b1;
                accept          = rst_ni & bus.req_valid_i;
                if (bus.req_valid_i) begin
                    state_d = (LATENCY > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                bus.resp_valid_o = 1'b1;
                if (bus.resp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Wait counter and response capture; loads read the pre-edge array contents.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else if (accept) begin
            cnt_q   <= CNT_INIT;
            rdata_q <= (bus.req_we_i || misaligned) ? 32'd0 : mem[idx];
            err_q   <= misaligned;
        end else if (state_q == WAIT && cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    // Array write with per-lane enables; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (accept && bus.req_we_i && !misaligned) begin
            for (int k = 0; k < 4; k++) begin
                if (bus.req_be_i[k]) begin
                    mem[idx][8*k +: 8] <= bus.req_wdata_i[8*k +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder. Two instances share stimulus: one with
// LATENCY = 2 and one with LATENCY = 0 (selected by sel).
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic        valid = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [3:0]  be = 4'd0;
    logic        rr = 1'b1;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        int          acc;
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sbq[$];

    dmem_responder_if bus2 ();
    dmem_responder_if bus0 ();

    assign bus2.req_valid_i  = valid & ~sel;
    assign bus0.req_valid_i  = valid & sel;
    assign bus2.req_we_i     = we;
    assign bus0.req_we_i     = we;
    assign bus2.req_addr_i   = addr;
    assign bus0.req_addr_i   = addr;
    assign bus2.req_wdata_i  = wdata;
    assign bus0.req_wdata_i  = wdata;
    assign bus2.req_be_i     = be;
    assign bus0.req_be_i     = be;
    assign bus2.resp_ready_i = rr;
    assign bus0.resp_ready_i = rr;

    logic        rdy, rv, rerr;
    logic [31:0] rdata;
    int          lat;
    assign rdy   = sel ? bus0.req_ready_o  : bus2.req_ready_o;
    assign rv    = sel ? bus0.resp_valid_o : bus2.resp_valid_o;
    assign rdata = sel ? bus0.resp_rdata_o : bus2.resp_rdata_o;
    assign rerr  = sel ? bus0.resp_err_o   : bus2.resp_err_o;
    assign lat   = sel ? 0 : 2;

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus2)
    );
    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: latency check on the first cycle of valid, data check at handshake.
    logic rv_prev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rv && !rv_prev) begin
            if (sbq.size() > 0) chk("latency", 32'(cyc), 32'(sbq[0].acc + lat));
            else chk("unexpected_valid", 32'd1, 32'd0);
        end
        if (rv && rr) begin
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("resp_rdata", rdata, e.rdata);
                chk("resp_err", 32'(rerr), 32'(e.err));
            end else begin
                chk("spurious_resp", 32'd1, 32'd0);
            end
        end
        rv_prev <= rv;
    end

    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] b, input logic [31:0] er, input logic ee);
        int n = 0;
        exp_t e;
        @(negedge clk);
        we = w; addr = a; wdata = d; be = b; valid = 1'b1;
        while (!rdy && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n == 20) begin
            chk("accept_timeout", 32'd1, 32'd0);
            valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            e.acc = cyc; e.rdata = er; e.err = ee;
            sbq.push_back(e);
            valid = 1'b0;
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (sbq.size() > 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() > 0) begin
            chk("resp_timeout", 32'(sbq.size()), 32'd0);
            sbq.delete();
        end
    endtask

    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, input logic [31:0] er, input logic ee);
        issue(w, a, d, b, er, ee);
        wait_done();
    endtask

    // Two reset cycles with a store presented; it must not be accepted.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        we = 1'b1; addr = 32'h10; wdata = 32'hFFFF_FFFF; be = 4'hF; valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("rst_req_ready", 32'(rdy), 32'd1);
            chk("rst_resp_valid", 32'(rv), 32'd0);
            chk("rst_rdata", rdata, 32'd0);
            chk("rst_err", 32'(rerr), 32'd0);
        end
        valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_no_resp", 32'(rv), 32'd0);
    endtask

    initial begin
        logic [31:0] held;
        int n;
        do_reset();

        // Full store, readback, byte-lane merge, no-op store.
        xfer(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0);
        xfer(1'b0, 32'h10, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0);
        xfer(1'b1, 32'h10, 32'h1122_3344, 4'h5, 32'h0, 1'b0);
        xfer(1'b0, 32'h10, 32'h0,         4'h0, 32'hDE22_BE44, 1'b0);
        xfer(1'b1, 32'h10, 32'hAAAA_AAAA, 4'h0, 32'h0, 1'b0);
        xfer(1'b0, 32'h10, 32'h0,         4'h0, 32'hDE22_BE44, 1'b0);

        // Store presented during reset must not commit.
        do_reset();
        xfer(1'b0, 32'h10, 32'h0, 4'h0, 32'hDE22_BE44, 1'b0);

        // Backpressure: response held for 5 cycles.
        rr = 1'b0;
        issue(1'b0, 32'h10, 32'h0, 4'h0, 32'hDE22_BE44, 1'b0);
        n = 0;
        while (!rv && n < 10) begin
            @(negedge clk);
            n++;
        end
        held = rdata;
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", 32'(rv), 32'd1);
            chk("bp_rdata_stable", rdata, held);
            chk("bp_req_ready", 32'(rdy), 32'd0);
        end
        @(posedge clk);
        #1 rr = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_release_ready", 32'(rdy), 32'd1);
        chk("bp_release_valid", 32'(rv), 32'd0);
        wait_done();

        // Misaligned accesses.
`ifdef DMEM_MISALIGN_ERR_EN
        xfer(1'b1, 32'h13, 32'h0102_0304, 4'hF, 32'h0, 1'b1);
        xfer(1'b0, 32'h10, 32'h0,         4'h0, 32'hDE22_BE44, 1'b0);
        xfer(1'b0, 32'h11, 32'h0,         4'h0, 32'h0, 1'b1);
`else
        xfer(1'b1, 32'h13, 32'h0102_0304, 4'hF, 32'h0, 1'b0);
        xfer(1'b0, 32'h10, 32'h0,         4'h0, 32'h0102_0304, 1'b0);
        xfer(1'b0, 32'h11, 32'h0,         4'h0, 32'h0102_0304, 1'b0);
`endif

        // Zero-latency instance: address wrap at 4 KiB.
        @(negedge clk);
        sel = 1'b1;
        xfer(1'b1, 32'h1004, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0);
        xfer(1'b0, 32'h0004, 32'h0,         4'h0, 32'hCAFE_F00D, 1'b0);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
